ld_align_buf: RTL
=================

LD_ALIGN_BUF -- requirements
Module: ld_align_buf

Interface
- REQ-001 SHALL have parameter DW, default 32, meaning the data-path width in bits; legal values are 32 and 64.
- REQ-002 SHALL have parameter OW, default 3, meaning the load-op code width.
- REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit, meaning the reset; it is asynchronous and active-high.
- REQ-005 SHALL have port flush, input, 1 bit, meaning discard all buffered loads.
- REQ-006 SHALL have port in_valid, input, 1 bit, meaning a load beat is offered.
- REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block accepts the beat this cycle.
- REQ-008 SHALL have port in_op, input, OW bits, meaning the load-op code from the shared package.
- REQ-009 SHALL have port in_addr, input, log2(DW/8) bits, meaning the byte offset within the data word.
- REQ-010 SHALL have port in_data, input, DW bits, meaning the raw memory word.
- REQ-011 SHALL have port out_valid, output, 1 bit, meaning the head entry is valid.
- REQ-012 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the head entry.
- REQ-013 SHALL have port out_data, output, DW bits, meaning the aligned and extended result.
- REQ-014 SHALL have port out_misalign, output, 1 bit, meaning the head load was misaligned.

Function
- REQ-015 SHALL extract and extend data per op:
  - LB/LBU: byte at in_addr, sign-/zero-extended to DW.
  - LH/LHU: halfword at in_addr[..:1], sign-/zero-extended.
  - LW/LWU: word at in_addr[..:2], sign-/zero-extended; when DW=32, LW and LWU are identical.
  - LD: whole word; valid only when DW=64.
- REQ-016 SHALL define misalignment as any of:
  - LH/LHU with in_addr[0]=1;
  - LW/LWU with in_addr[1:0]≠0;
  - LD with in_addr[2:0]≠0.
- REQ-017 SHALL produce out_data=0 and out_misalign=0 for an undefined op, or for LD when DW=32.
- REQ-018 SHALL store the extracted result, not the raw word, in a 2-entry FIFO; the push condition is in_valid&&in_ready.
- REQ-019 SHALL drive in_ready=1 exactly when fewer than 2 entries are held; in_ready is registered and independent of out_ready.
- REQ-020 SHALL have one-cycle latency: a beat accepted at edge N is visible on out_* after edge N.
- REQ-021 SHALL sustain 1 beat/cycle when out_ready is held high.
- REQ-022 SHALL pop on out_valid&&out_ready.
- REQ-023 SHALL, on simultaneous push and pop with 1 entry held, hold the count at 1, make the new entry the head, and keep in_ready=1.
- REQ-024 SHALL hold out_data and out_misalign stable while out_valid=1 and out_ready=0.
- REQ-025 SHALL take flush priority over push and pop: after the edge the count is 0, and the beat offered that cycle is dropped.
- REQ-026 SHALL implement read/write pointers as 1-bit wrapping counters and the occupancy as a 2-bit count in the range 0..2.

Reset
- REQ-027 SHALL, on rst=1 and independent of clk, immediately clear the count and both pointers.
- REQ-028 SHALL drive out_valid=0, in_ready=1, out_data=0 and out_misalign=0 while rst=1 and after its release.
- REQ-029 SHALL discard all held entries when reset is asserted mid-operation; there is no partial drain.
- REQ-030 SHALL allow the entry storage to remain un-reset, provided out_data is masked to 0 when out_valid=0.

Configuration
- REQ-031 SHALL, with macro LD_ALIGN_CHK_EN defined, drive out_misalign=1 and out_data=0 for a misaligned load.
- REQ-032 SHALL, without LD_ALIGN_CHK_EN, tie out_misalign to 0 and return out_data=0 for a misaligned load; this matches the legacy behaviour.

Structure
- REQ-033 SHALL place the following in a shared package ld_pkg:
  - op codes: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWU=5, LD=6;
  - OW;
  - the entry struct {data[DW], misalign}.
- REQ-034 SHALL contain one combinational sub-module, ld_extract, which implements REQ-015 to REQ-017 and feeds the FIFO write port.

Verification
- REQ-035 SHALL cover: DW=32, LB, addr=3, data=0x80FF_FF01 -> out_data=0xFFFF_FF80 one cycle later, out_misalign=0.
- REQ-036 SHALL cover: DW=32, LHU, addr=2, data=0xBEEF_1234 -> out_data=0x0000_BEEF; LH, same inputs -> out_data=0xFFFF_BEEF.
- REQ-037 SHALL cover: DW=64, LW, addr=4, data=0x8000_0001_0000_0002 -> out_data=0xFFFF_FFFF_8000_0001; LD, addr=4 -> out_misalign=1 with LD_ALIGN_CHK_EN, out_data=0 in both builds.
- REQ-038 SHALL cover: out_ready=0 with 3 beats offered -> 2 accepted, in_ready=0 after the second edge, head value stable; out_ready=1 -> beats drain in order, in_ready returns to 1.
- REQ-039 SHALL cover: 1 entry held, push and pop in the same cycle -> count stays 1 and the new data is the head; flush with in_valid=1 -> out_valid=0 next cycle and no entry captured.
- REQ-040 SHALL cover: rst pulsed asynchronously between edges with 2 entries held -> out_valid=0 and in_ready=1 immediately, and the first post-reset beat appears one cycle after its acceptance.

Source files
------------

// File: rtl/ld_pkg.sv
// Shared load-op definitions for the load alignment buffer.
// The entry data field is sized for the widest legal data path (64 bits);
// narrower instances zero-fill and ignore the upper half.
package ld_pkg;

    localparam int unsigned OW        = 3;
    localparam int unsigned LD_DW_MAX = 64;

    typedef enum logic [OW-1:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        LWU = 3'd5,
        LD  = 3'd6
    } ld_op_e;

    typedef struct packed {
        logic [LD_DW_MAX-1:0] data;
        logic                 misalign;
    } ld_entry_t;

endpackage

// File: rtl/ld_align_buf_if.sv
// Load-beat producer/consumer bundle for ld_align_buf.
// master: load issuer and result consumer; slave: the buffer itself.
interface ld_align_buf_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned OW = 3
);

    localparam int unsigned AW = $clog2(DW / 8);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_op;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_misalign;

    modport master (
        output flush, in_valid, in_op, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_misalign
    );

    modport slave (
        input  flush, in_valid, in_op, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_data, out_misalign
    );

endinterface

// File: rtl/ld_extract.sv
// Combinational load extraction: selects the addressed byte/half/word,
// sign- or zero-extends it and flags misalignment.
// Optional feature macro: LD_ALIGN_CHK_EN (report misalignment on the entry).
module ld_extract #(
    parameter int unsigned DW = 32,
    parameter int unsigned OW = 3,
    localparam int unsigned AW = $clog2(DW / 8)
) (
    input  logic [OW-1:0]     op,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     data,
    output ld_pkg::ld_entry_t ent
);

    import ld_pkg::*;

    logic [DW-1:0] shifted;
    logic [DW-1:0] res;
    logic          mis;

    // Shift the addressed byte to bit 0, then size/extend per op; a misaligned
    // access always yields zero data. LD uses the shifted word too, which equals
    // the raw word whenever it is aligned.
    always_comb begin
        shifted = data >> {addr, 3'b000};
        res     = '0;
        mis     = 1'b0;
        case (op)
            OW'(LB):  res = DW'($signed(shifted[7:0]));
            OW'(LBU): res = DW'(shifted[7:0]);
            OW'(LH): begin
                mis = addr[0];
                res = DW'($signed(shifted[15:0]));
            end
            OW'(LHU): begin
                mis = addr[0];
                res = DW'(shifted[15:0]);
            end
            OW'(LW): begin
                mis = (addr[1:0] != 2'b00);
                res = DW'($signed(shifted[31:0]));
            end
            OW'(LWU): begin
                mis = (addr[1:0] != 2'b00);
                res = DW'(shifted[31:0]);
            end
            OW'(LD): begin
                if (DW == 64) begin
                    mis = (addr != '0);
                    res = shifted;
                end
            end
            default: ;
        endcase
        if (mis) begin
            res = '0;
        end
`ifdef LD_ALIGN_CHK_EN
        ent.misalign = mis;
`else
        ent.misalign = 1'b0;
`endif
        ent.data = LD_DW_MAX'(res);
    end

endmodule

// File: rtl/ld_align_buf.sv
// Load alignment buffer: extracts/extends each accepted load beat and holds
// the results in a 2-entry FIFO with a registered in_ready.
// Optional feature macro: LD_ALIGN_CHK_EN (passed through ld_extract).
module ld_align_buf #(
    parameter int unsigned DW = 32,
    parameter int unsigned OW = 3
) (
    input logic           clk,
    input logic           rst,
    ld_align_buf_if.slave bus
);

    import ld_pkg::*;

    ld_entry_t  ext_ent;
    ld_entry_t  mem_q [2];
    ld_entry_t  mem_d [2];
    ld_entry_t  head;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid;
    logic       push;
    logic       pop;

    ld_extract #(
        .DW(DW),
        .OW(OW)
    ) u_extract (
        .op  (bus.in_op),
        .addr(bus.in_addr),
        .data(bus.in_data),
        .ent (ext_ent)
    );

    // FIFO next state: flush wins over push/pop; in_ready follows next occupancy.
    always_comb begin
        out_valid = (cnt_q != 2'd0);
        push      = bus.in_valid && in_ready_q;
        pop       = out_valid && bus.out_ready;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        if (bus.flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = ext_ent;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: ;
            endcase
        end
        in_ready_d = (cnt_d < 2'd2);
    end

    // Control state: pointers, occupancy and in_ready, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Entry storage is not reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head presentation, zero whenever no entry is held.
    always_comb begin
        head             = mem_q[rd_ptr_q];
        bus.in_ready     = in_ready_q;
        bus.out_valid    = out_valid;
        bus.out_data     = out_valid ? DW'(head.data) : '0;
        bus.out_misalign = out_valid && head.misalign;
    end

endmodule
